// File: rtl/fifo_example_pkg.sv
// Shared types and constants for the example FIFO stack sequencer.
// Holds state encoding, counter widths and a saturating increment helper.
package fifo_example_pkg;

    localparam int CNT_W  = 12;
    localparam int DROP_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FILL  = ST_FILL,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_e;

    function automatic logic [DROP_W-1:0] sat_inc(
        input logic [DROP_W-1:0] v
    );
        return (&v) ? v : v + DROP_ONE;
    endfunction

endpackage

// File: rtl/period_strobe.sv
// Wrapping period counter: counts 0..PERIOD-1 while enabled and
// flags a tick on the last count of each period.
module period_strobe
    import fifo_example_pkg::*;
#(
    parameter logic [CNT_W-1:0] PERIOD = 12'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i & (cnt_q == PERIOD - CNT_ONE);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_rw_scheduler.sv
// Periodic write/read strobe sequencer with occupancy tracking and
// blocked-event statistics; runs a prefill/run/drain session.
module fifo_rw_scheduler
    import fifo_example_pkg::*;
#(
    parameter logic [CNT_W-1:0] STACK_WIDTH  = 12'd5,
    parameter logic [CNT_W-1:0] WR_EN_PERIOD = 12'd100,
    parameter logic [CNT_W-1:0] RD_EN_PERIOD = 12'd35,
    parameter logic [CNT_W-1:0] PREFILL      = 12'd2
) (
    input  logic              clk,
    input  logic              kill,
    input  logic              start,
    input  logic              stop,
    output logic              wr_en,
    output logic [CNT_W-1:0]  wr_data,
    output logic              rd_en,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] wr_drop_cnt,
    output logic [DROP_W-1:0] rd_skip_cnt,
    output logic [1:0]        state,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [CNT_W-1:0]  wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W-1:0] skip_q, skip_d;
    logic              busy_q, busy_d;

    logic idle;
    logic go;
    logic wr_tick;
    logic rd_tick;
    logic wr_act;
    logic rd_act;
    logic do_wr;
    logic do_rd;

    assign idle   = (state_q == IDLE);
    assign go     = idle & start;
    assign wr_act = (state_q == FILL) | (state_q == RUN);
    assign rd_act = (state_q == RUN) | (state_q == DRAIN);

    // Counters sit cleared in IDLE, so a session always starts at count 0.
    period_strobe #(
        .PERIOD (WR_EN_PERIOD)
    ) u_wr_strobe (
        .clk    (clk),
        .rst_n  (kill),
        .clr_i  (idle),
        .en_i   (~idle),
        .tick_o (wr_tick)
    );

    period_strobe #(
        .PERIOD (RD_EN_PERIOD)
    ) u_rd_strobe (
        .clk    (clk),
        .rst_n  (kill),
        .clr_i  (idle),
        .en_i   (~idle),
        .tick_o (rd_tick)
    );

    // Full/empty gate on the registered flags, i.e. pre-update level.
    assign do_wr = wr_tick & wr_act & ~full_q;
    assign do_rd = rd_tick & rd_act & ~empty_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (level_q >= PREFILL) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (level_q == '0 && !rd_en_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d   = do_wr;
        rd_en_d   = do_rd;
        wr_data_d = wr_en_q ? wr_data_q + CNT_ONE : wr_data_q;
        level_d   = level_q;
        drop_d    = drop_q;
        skip_d    = skip_q;
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + CNT_ONE;
            2'b01:   level_d = level_q - CNT_ONE;
            default: level_d = level_q;
        endcase
        if (wr_tick && wr_act && full_q) begin
            drop_d = sat_inc(drop_q);
        end
        if (rd_tick && (state_q == RUN) && empty_q) begin
            skip_d = sat_inc(skip_q);
        end
        if (go) begin
            wr_data_d = '0;
            level_d   = '0;
            drop_d    = '0;
            skip_d    = '0;
        end
        full_d  = (level_d == STACK_WIDTH);
        empty_d = (level_d == '0);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_data_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            drop_q    <= '0;
            skip_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_data_q <= wr_data_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            drop_q    <= drop_d;
            skip_q    <= skip_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign rd_en       = rd_en_q;
    assign level       = level_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign wr_drop_cnt = drop_q;
    assign rd_skip_cnt = skip_q;
    assign state       = state_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fifo_rw_scheduler.sv
// Directed bench: seven scheduler configurations run side by side,
// checked against a hand-computed vector table plus stop/kill sequences.
module tb_fifo_rw_scheduler;

    localparam int N = 7;
    // A=default B=fullblock C=equal D=saturate W=wrap E=stop F=kill
    localparam int SWP [N] = '{5, 5, 5, 1, 5, 5, 2};
    localparam int WRP [N] = '{100, 4, 10, 1, 1, 2, 2};
    localparam int RDP [N] = '{35, 50, 10, 4095, 1, 50, 50};
    localparam int PFP [N] = '{2, 5, 1, 1, 0, 2, 2};

    typedef struct packed {
        logic        we;
        logic [11:0] wd;
        logic        re;
        logic [11:0] lv;
        logic        fu;
        logic        em;
        logic [1:0]  st;
        logic        bz;
        logic [7:0]  dr;
        logic [7:0]  sk;
    } obs_t;

    typedef struct {
        int   dut;
        int   cyc;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic kill_all = 1'b1;
    logic start_all = 1'b0;
    logic kill_f = 1'b1;
    logic start_f = 1'b0;
    logic stop_e = 1'b0;

    logic [N-1:0] kill_v, start_v, stop_v;
    logic [N-1:0] v_we, v_re, v_fu, v_em, v_bz;
    logic [11:0]  v_wd [N];
    logic [11:0]  v_lv [N];
    logic [7:0]   v_dr [N];
    logic [7:0]   v_sk [N];
    logic [1:0]   v_st [N];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[$];

    assign kill_v  = {kill_all & kill_f, {(N-1){kill_all}}};
    assign start_v = {start_all | start_f, {(N-1){start_all}}};
    assign stop_v  = {1'b0, stop_e, 5'b0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fifo_rw_scheduler #(
            .STACK_WIDTH  (12'(SWP[g])),
            .WR_EN_PERIOD (12'(WRP[g])),
            .RD_EN_PERIOD (12'(RDP[g])),
            .PREFILL      (12'(PFP[g]))
        ) u_dut (
            .clk         (clk),
            .kill        (kill_v[g]),
            .start       (start_v[g]),
            .stop        (stop_v[g]),
            .wr_en       (v_we[g]),
            .wr_data     (v_wd[g]),
            .rd_en       (v_re[g]),
            .level       (v_lv[g]),
            .full        (v_fu[g]),
            .empty       (v_em[g]),
            .wr_drop_cnt (v_dr[g]),
            .rd_skip_cnt (v_sk[g]),
            .state       (v_st[g]),
            .busy        (v_bz[g])
        );
    end

    function automatic obs_t mk(bit we, int wd, bit re, int lv,
                                bit fu, bit em, int st, int dr, int sk);
        obs_t r;
        r.we = we;
        r.wd = 12'(wd);
        r.re = re;
        r.lv = 12'(lv);
        r.fu = fu;
        r.em = em;
        r.st = 2'(st);
        r.bz = (st != 0);
        r.dr = 8'(dr);
        r.sk = 8'(sk);
        return r;
    endfunction

    function automatic obs_t get(int i);
        obs_t r;
        r.we = v_we[i];
        r.wd = v_wd[i];
        r.re = v_re[i];
        r.lv = v_lv[i];
        r.fu = v_fu[i];
        r.em = v_em[i];
        r.st = v_st[i];
        r.bz = v_bz[i];
        r.dr = v_dr[i];
        r.sk = v_sk[i];
        return r;
    endfunction

    task automatic chk(string nm, obs_t a, obs_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got we=%0b wd=%0d re=%0b lv=%0d fu=%0b em=%0b st=%0d bz=%0b dr=%0d sk=%0d, expected we=%0b wd=%0d re=%0b lv=%0d fu=%0b em=%0b st=%0d bz=%0b dr=%0d sk=%0d",
                     nm, a.we, a.wd, a.re, a.lv, a.fu, a.em, a.st, a.bz, a.dr, a.sk,
                     e.we, e.wd, e.re, e.lv, e.fu, e.em, e.st, e.bz, e.dr, e.sk);
        end
    endtask

    task automatic chk_int(string nm, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    task automatic wait_cyc(int n);
        wait (cyc >= n);
        #1;
    endtask

    task automatic add(int d, int c, obs_t e);
        vec_t v;
        v.dut = d;
        v.cyc = c;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            wait_cyc(tbl[i].cyc);
            chk($sformatf("tbl%0d_dut%0d_cyc%0d", i, tbl[i].dut, tbl[i].cyc),
                get(tbl[i].dut), tbl[i].exp);
        end
    endtask

    task automatic seq_stop();
        int bad = 0;
        int nrd = 0;
        wait_cyc(6);
        chk("stop_pre", get(5), mk(1, 2, 0, 3, 0, 0, 2, 0, 0));
        stop_e = 1'b1;
        wait_cyc(7);
        stop_e = 1'b0;
        chk("stop_drain", get(5), mk(0, 3, 0, 3, 0, 0, 3, 0, 0));
        for (int c = 8; c <= 152; c++) begin
            wait_cyc(c);
            if (v_we[5]) bad++;
            if (v_re[5]) nrd++;
            if (c == 150) chk("stop_last_rd", get(5), mk(0, 3, 1, 0, 0, 1, 3, 0, 0));
            if (c == 151) chk("stop_hold", get(5), mk(0, 3, 0, 0, 0, 1, 3, 0, 0));
            if (c == 152) chk("stop_idle", get(5), mk(0, 3, 0, 0, 0, 1, 0, 0, 0));
        end
        chk_int("stop_no_wr", bad, 0);
        chk_int("stop_rd_pulses", nrd, 3);
    endtask

    task automatic seq_kill();
        wait_cyc(19);
        chk("kill_pre", get(6), mk(0, 2, 0, 2, 1, 0, 2, 7, 0));
        #1 kill_f = 1'b0;
        #1 chk("kill_async", get(6), mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        #1 kill_f = 1'b1;
        start_f = 1'b1;
        wait_cyc(20);
        start_f = 1'b0;
        chk("kill_restart", get(6), mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        wait_cyc(22);
        chk("kill_first_wr", get(6), mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        add(0, 0,    mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        add(3, 0,    mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        add(4, 0,    mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        add(3, 1,    mk(1, 0, 0, 1, 1, 0, 1, 0, 0));
        add(4, 1,    mk(1, 0, 0, 1, 0, 0, 2, 0, 0));
        add(3, 2,    mk(0, 1, 0, 1, 1, 0, 2, 1, 0));
        add(4, 2,    mk(1, 1, 1, 1, 0, 0, 2, 0, 0));
        add(2, 10,   mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
        add(2, 11,   mk(0, 1, 0, 1, 0, 0, 2, 0, 0));
        add(1, 20,   mk(1, 4, 0, 5, 1, 0, 1, 0, 0));
        add(2, 20,   mk(1, 1, 1, 1, 0, 0, 2, 0, 0));
        add(1, 21,   mk(0, 5, 0, 5, 1, 0, 2, 0, 0));
        add(1, 24,   mk(0, 5, 0, 5, 1, 0, 2, 1, 0));
        add(1, 50,   mk(0, 5, 1, 4, 0, 0, 2, 7, 0));
        add(1, 52,   mk(1, 5, 0, 5, 1, 0, 2, 7, 0));
        add(0, 99,   mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        add(0, 100,  mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
        add(0, 101,  mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
        add(2, 120,  mk(1, 11, 1, 1, 0, 0, 2, 0, 0));
        add(2, 121,  mk(0, 12, 0, 1, 0, 0, 2, 0, 0));
        add(0, 175,  mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
        add(0, 200,  mk(1, 1, 0, 2, 0, 0, 1, 0, 0));
        add(0, 201,  mk(0, 2, 0, 2, 0, 0, 2, 0, 0));
        add(0, 210,  mk(0, 2, 1, 1, 0, 0, 2, 0, 0));
        add(0, 245,  mk(0, 2, 1, 0, 0, 1, 2, 0, 0));
        add(3, 255,  mk(0, 1, 0, 1, 1, 0, 2, 254, 0));
        add(3, 256,  mk(0, 1, 0, 1, 1, 0, 2, 255, 0));
        add(0, 280,  mk(0, 2, 0, 0, 0, 1, 2, 0, 1));
        add(0, 300,  mk(1, 2, 0, 1, 0, 0, 2, 0, 1));
        add(3, 300,  mk(0, 1, 0, 1, 1, 0, 2, 255, 0));
        add(4, 4096, mk(1, 4095, 1, 1, 0, 0, 2, 0, 0));
        add(4, 4097, mk(1, 0, 1, 1, 0, 0, 2, 0, 0));
        add(4, 4098, mk(1, 1, 1, 1, 0, 0, 2, 0, 0));

        #1 kill_all = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_dut%0d", i), get(i),
                mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        #1 kill_all = 1'b1;
        start_all = 1'b1;
        @(posedge clk);
        #1 start_all = 1'b0;
        fork
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
            end
        join_none
        fork
            run_table();
            seq_stop();
            seq_kill();
        join
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rw_scheduler.md
Name: fifo_rw_scheduler

Overview:
Sequencer for the 12-bit example FIFO stack. Generates periodic write/read enable strobes at the configured periods, supplies an incrementing write-data pattern and tracks occupancy. Suppresses writes when full and reads when empty, and counts blocked events. Runs a prefill/run/drain session controlled by start/stop; sits between the top level and the FIFO storage.

Parameters:
STACK_WIDTH, 12'd5, FIFO depth in entries (1..4095).
WR_EN_PERIOD, 12'd100, cycles between write ticks (>=1).
RD_EN_PERIOD, 12'd35, cycles between read ticks (>=1).
PREFILL, 12'd2, level required before reads are enabled (0..STACK_WIDTH).

Ports:
clk  in  1  clock, rising edge.
kill  in  1  asynchronous active-low reset.
start  in  1  begin session; sampled in IDLE only.
stop  in  1  end session; sampled in FILL/RUN only.
wr_en  out  1  one-cycle FIFO write strobe.
wr_data  out  12  write data; valid when wr_en=1.
rd_en  out  1  one-cycle FIFO read strobe.
level  out  12  current occupancy.
full  out  1  level==STACK_WIDTH.
empty  out  1  level==0.
wr_drop_cnt  out  8  write ticks blocked by full; saturates at 255.
rd_skip_cnt  out  8  read ticks in RUN blocked by empty; saturates at 255.
state  out  2  IDLE=0, FILL=1, RUN=2, DRAIN=3.
busy  out  1  state!=IDLE.

Behaviour:
- Reset (kill=0, asynchronous): state=IDLE; wr_en=rd_en=0; wr_data=0; level=0; full=0; empty=1; drop/skip counters=0; busy=0. Takes effect mid-session immediately; no drain.
- All outputs are registered.
- FSM:
  - IDLE->FILL on start.
  - FILL->RUN when registered level>=PREFILL; with PREFILL=0 this occurs on the first FILL cycle.
  - FILL->DRAIN or RUN->DRAIN on stop; stop has priority over the FILL->RUN transition.
  - DRAIN->IDLE when level==0 and rd_en=0.
  - start outside IDLE and stop in IDLE/DRAIN are ignored.
- On the IDLE->FILL edge, clear: both period counters, wr_data, level, wr_drop_cnt, rd_skip_cnt.
- Period counters (12-bit):
  - Run in FILL/RUN/DRAIN; hold at 0 in IDLE.
  - Count 0..PERIOD-1 and wrap.
  - A tick occurs when count==PERIOD-1.
  - With start sampled at edge E0, the first tick is evaluated at edge E(PERIOD), so the first strobe is high in the cycle after E(PERIOD).
- Write:
  - On a write tick in FILL/RUN with full=0: wr_en=1 for one cycle, wr_data holds the current pattern.
  - wr_data increments after each wr_en and wraps 4095->0.
  - Tick with full=1: no strobe; wr_drop_cnt++ (saturating).
  - Write ticks in DRAIN are neither counted nor acted on.
- Read:
  - On a read tick in RUN/DRAIN with empty=0: rd_en=1 for one cycle.
  - Tick in RUN with empty=1: rd_skip_cnt++ (saturating).
  - Read ticks in FILL are ignored.
- Occupancy:
  - level += wr_en, -= rd_en, evaluated with the strobes being issued.
  - Simultaneous write and read leave level unchanged.
  - full/empty are derived from the registered level before the update, so a write tick while full is blocked even if a read is issued in the same cycle.
  - level never exceeds STACK_WIDTH and never underflows.
- Equal periods: both ticks land in the same cycle; rules above apply unchanged.

Decomposition:
- Package fifo_example_pkg holds:
  - state encoding localparams (IDLE/FILL/RUN/DRAIN);
  - CNT_W=12 and DROP_W=8.
- Sub-module period_strobe: 12-bit wrapping counter with synchronous clear and enable, outputs a tick. Instantiated twice (write, read).
- FSM, occupancy and statistics logic live in fifo_rw_scheduler.

Test Plan:
1. Defaults; kill released; start pulse at edge 0.
   - wr_en at cycles 100 and 200 (wr_data 0, 1).
   - state=RUN after level reaches 2.
   - rd_en drains level to 0 before cycle 300.
   - rd_skip_cnt>=1 by cycle 300.
2. WR_EN_PERIOD=4, RD_EN_PERIOD=50, STACK_WIDTH=5, PREFILL=5.
   - level=5, full=1 after the 5th write (cycle 20); state=RUN.
   - Write tick at cycle 24: no wr_en, wr_drop_cnt=1.
   - First read at cycle 50: level=4.
3. WR=RD=10, PREFILL=1.
   - Write at cycle 10: level=1.
   - Cycle 20: wr_en and rd_en together; level stays 1 for 10 further ticks; counters stay 0.
4. Stop asserted in RUN with level=3.
   - state=DRAIN next cycle; no further wr_en.
   - Three rd_en pulses bring level to 0, then state=IDLE, busy=0.
5. kill pulled low in RUN with level=2 and wr_drop_cnt=7.
   - All outputs return to reset values with no clock edge; a new start resumes from wr_data=0.
6. WR=1, RD=4095, STACK_WIDTH=1, PREFILL=1; hold for >300 cycles.
   - wr_drop_cnt saturates at 255.
   - A separate run of 4097 writes shows wr_data wrapping 4095->0.
